hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller on the consumer side of the ID/EX register.
//  - Reads the EX-stage view of the instruction: lw_idex, rf_wen_idex, destination index, branch/jal/jr resolution.
//  - Compares it against the source indices of the instruction now in ID.
//  - Drives the hold/flush/bubble controls back into PC, IF/ID and ID/EX.
//  - Keeps saturating stall/flush performance counters.
// PARAMETERS
//  REG_AW      4   register index width (16-entry register file)
//  FLUSH_CYC   1   cycles of squash per redirect (>=1); >1 for delayed PC redirect
//  CNT_W       16  width of performance counters
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-high reset
//  lw_idex        in   1       instruction in EX is a load
//  rf_wen_idex    in   1       instruction in EX writes register file
//  rdest_a_idex   in   REG_AW  destination index of instruction in EX
//  rs1_a_ifid     in   REG_AW  source-1 index of instruction in ID
//  rs2_a_ifid     in   REG_AW  source-2 index of instruction in ID
//  rs1_use_ifid   in   1       ID instruction reads rs1
//  rs2_use_ifid   in   1       ID instruction reads rs2
//  redirect_ex    in   1       taken branch, jal or jr resolved in EX this cycle
//  pc_wen         out  1       PC may update
//  ifid_wen       out  1       IF/ID may load
//  ifid_flush     out  1       IF/ID loads a NOP
//  idex_bubble    out  1       ID/EX loads zeroed controls (rf_wen, dmem_wen, branch, jal, jr, lw = 0)
//  stall_cnt      out  CNT_W   load-use stall cycles, saturating
//  flush_cnt      out  CNT_W   redirect events, saturating
// BEHAVIOUR
//  - Load-use detection (combinational):
//    lu = lw_idex & rf_wen_idex & ((rs1_use_ifid & rs1_a_ifid==rdest_a_idex) | (rs2_use_ifid & rs2_a_ifid==rdest_a_idex)).
//    No special case for register 0.
//  - FSM states and outputs:
//    IDLE: default.
//    FLUSH: squash cycles remaining after a redirect; down-counter rem, width clog2(FLUSH_CYC+1).
//  - Outputs are combinational from state and inputs, with this priority:
//    1. redirect_ex (any state): pc_wen=1, ifid_wen=1, ifid_flush=1, idex_bubble=1.
//       If FLUSH_CYC>1: next=FLUSH, rem=FLUSH_CYC-1. Otherwise stay IDLE.
//       A redirect arriving in FLUSH restarts rem.
//    2. FLUSH state: ifid_flush=1, idex_bubble=1, pc_wen=1, ifid_wen=1.
//       rem decrements; at rem==1 the next state is IDLE. lu is ignored.
//    3. IDLE with lu: pc_wen=0, ifid_wen=0, ifid_flush=0, idex_bubble=1 (one bubble).
//       On the following cycle the load has left EX, so lu drops without extra state.
//    4. IDLE otherwise: pc_wen=1, ifid_wen=1, ifid_flush=0, idex_bubble=0.
//  - Counters:
//    stall_cnt +1 on each cycle case 3 applies.
//    flush_cnt +1 on each cycle redirect_ex=1.
//    Both saturate at all-ones; no wrap.
//  - Reset (async, while rst=1): state=IDLE, rem=0, stall_cnt=0, flush_cnt=0.
//    Outputs forced to pc_wen=0, ifid_wen=0, ifid_flush=1, idex_bubble=1, so the pipeline fills with NOPs.
//    Outputs revert to case 4 after the first clk edge with rst=0.
//  - Reset asserted mid-FLUSH or mid-stall aborts immediately; no residual squash after release.
//  - Simultaneous lu and redirect: redirect wins; no stall counted.
// TESTING
//  1. lw_idex=1, rf_wen_idex=1, rdest=5, rs1=5, rs1_use=1 for one cycle
//     -> pc_wen=0, ifid_wen=0, idex_bubble=1 that cycle; stall_cnt 0->1.
//  2. Same as 1 with rs1_use=0, rs2=5, rs2_use=0
//     -> no stall; all controls at case-4 values; stall_cnt unchanged.
//  3. FLUSH_CYC=3: redirect_ex pulse
//     -> ifid_flush=idex_bubble=1 for exactly 3 cycles; flush_cnt +1.
//     Second pulse in cycle 2 -> squash extends to 3 cycles past the second pulse; flush_cnt=2.
//  4. lu and redirect_ex asserted together
//     -> pc_wen=1, ifid_flush=1, idex_bubble=1; stall_cnt unchanged.
//  5. Preload stall_cnt to 16'hFFFE, then 3 stall cycles -> counter holds 16'hFFFF.
//     rst pulse mid-FLUSH -> outputs go to reset values immediately; IDLE outputs on the first edge after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Load-use / redirect hazard controller for the ID/EX boundary: drives PC, IF/ID and
// ID/EX hold/flush/bubble controls and keeps saturating stall and flush counters.
module hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lw_idex,
    input  logic              rf_wen_idex,
    input  logic [REG_AW-1:0] rdest_a_idex,
    input  logic [REG_AW-1:0] rs1_a_ifid,
    input  logic [REG_AW-1:0] rs2_a_ifid,
    input  logic              rs1_use_ifid,
    input  logic              rs2_use_ifid,
    input  logic              redirect_ex,
    output logic              pc_wen,
    output logic              ifid_wen,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int RW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;
    localparam logic [RW-1:0] REM_INIT = RW'(FLUSH_CYC - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic             rst_hold_q;
    logic             lu;
    logic             stall_evt;
    logic             flush_evt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Register 0 is deliberately not special-cased: a load to r0 still stalls its consumer.
    always_comb begin
        lu = lw_idex & rf_wen_idex &
             ((rs1_use_ifid & (rs1_a_ifid == rdest_a_idex)) |
              (rs2_use_ifid & (rs2_a_ifid == rdest_a_idex)));
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        // rst_hold_q keeps NOP fill active until the first edge after reset release.
        if (rst || rst_hold_q) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = IDLE;
            rem_d       = '0;
        end else if (redirect_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_evt   = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_d = FLUSH;
                rem_d   = REM_INIT;
            end else begin
                state_d = IDLE;
                rem_d   = '0;
            end
        end else if (state_q == FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            rem_d       = rem_q - RW'(1);
            if (rem_q <= RW'(1)) begin
                state_d = IDLE;
                rem_d   = '0;
            end
        end else if (lu) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            rst_hold_q  <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            rst_hold_q <= 1'b0;
            if (stall_evt) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush_evt) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYC=3): a driver queues hand-computed
// expectations per cycle, a monitor pops and compares them mid-cycle.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lw_idex = 1'b0;
    logic        rf_wen_idex = 1'b0;
    logic [3:0]  rdest_a_idex = '0;
    logic [3:0]  rs1_a_ifid = '0;
    logic [3:0]  rs2_a_ifid = '0;
    logic        rs1_use_ifid = 1'b0;
    logic        rs2_use_ifid = 1'b0;
    logic        redirect_ex = 1'b0;
    logic        pc_wen, ifid_wen, ifid_flush, idex_bubble;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [3:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // ctl = {pc_wen, ifid_wen, ifid_flush, idex_bubble}
    localparam logic [3:0] C_RUN = 4'b1100;
    localparam logic [3:0] C_STL = 4'b0001;
    localparam logic [3:0] C_SQ  = 4'b1111;
    localparam logic [3:0] C_RST = 4'b0011;

    hazard_ctrl #(.REG_AW(4), .FLUSH_CYC(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .lw_idex      (lw_idex),
        .rf_wen_idex  (rf_wen_idex),
        .rdest_a_idex (rdest_a_idex),
        .rs1_a_ifid   (rs1_a_ifid),
        .rs2_a_ifid   (rs2_a_ifid),
        .rs1_use_ifid (rs1_use_ifid),
        .rs2_use_ifid (rs2_use_ifid),
        .redirect_ex  (redirect_ex),
        .pc_wen       (pc_wen),
        .ifid_wen     (ifid_wen),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic red, input logic lw, input logic wen,
                        input logic [3:0] rd, input logic [3:0] s1, input logic u1,
                        input logic [3:0] s2, input logic u2,
                        input logic [3:0] ectl, input logic [15:0] esc,
                        input logic [15:0] efc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        redirect_ex  = red;
        lw_idex      = lw;
        rf_wen_idex  = wen;
        rdest_a_idex = rd;
        rs1_a_ifid   = s1;
        rs1_use_ifid = u1;
        rs2_a_ifid   = s2;
        rs2_use_ifid = u2;
        e.ctl = ectl;
        e.sc  = esc;
        e.fc  = efc;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic r, input logic [3:0] ectl, input logic [15:0] esc,
                        input logic [15:0] efc, input string nm);
        step(r, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, ectl, esc, efc, nm);
    endtask

    // Load to r9 with an ID consumer reading r9 on rs1: a load-use hazard.
    task automatic lu_step(input logic red, input logic [3:0] ectl, input logic [15:0] esc,
                           input logic [15:0] efc, input string nm);
        step(1'b0, red, 1'b1, 1'b1, 4'd9, 4'd9, 1'b1, 4'd2, 1'b0, ectl, esc, efc, nm);
    endtask

    // Monitor: the DUT presents its controls every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        logic [3:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_wen, ifid_wen, ifid_flush, idex_bubble};
                checks++;
                if (act !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL %s: got ctl=%b stall=%h flush=%h, expected ctl=%b stall=%h flush=%h",
                             e.nm, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        idle(1'b1, C_RST, 16'd0, 16'd0, "reset_a");
        idle(1'b1, C_RST, 16'd0, 16'd0, "reset_b");
        idle(1'b0, C_RST, 16'd0, 16'd0, "reset_release_hold");
        idle(1'b0, C_RUN, 16'd0, 16'd0, "idle_after_reset");

        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, C_STL, 16'd0, 16'd0, "lu_rs1");
        idle(1'b0, C_RUN, 16'd1, 16'd0, "after_lu_rs1");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 4'd5, 1'b0, C_RUN, 16'd1, 16'd0, "no_use_bits");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd3, 1'b1, 4'd7, 1'b1, C_STL, 16'd1, 16'd0, "lu_rs2");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b1, 4'd7, 1'b1, C_RUN, 16'd2, 16'd0, "load_no_wen");
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b1, 4'd7, 1'b1, C_RUN, 16'd2, 16'd0, "alu_no_load");
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 1'b0, C_STL, 16'd2, 16'd0, "lu_r0");
        idle(1'b0, C_RUN, 16'd3, 16'd0, "after_lu_r0");

        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, C_SQ, 16'd3, 16'd0, "redir_c0");
        idle(1'b0, C_SQ, 16'd3, 16'd1, "redir_c1");
        lu_step(1'b0, C_SQ, 16'd3, 16'd1, "redir_c2_lu_ignored");
        idle(1'b0, C_RUN, 16'd3, 16'd1, "redir_done");

        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, C_SQ, 16'd3, 16'd1, "redir2_first");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, C_SQ, 16'd3, 16'd2, "redir2_second");
        idle(1'b0, C_SQ, 16'd3, 16'd3, "redir2_ext1");
        idle(1'b0, C_SQ, 16'd3, 16'd3, "redir2_ext2");
        idle(1'b0, C_RUN, 16'd3, 16'd3, "redir2_done");

        lu_step(1'b1, C_SQ, 16'd3, 16'd3, "lu_and_redir");
        lu_step(1'b0, C_SQ, 16'd3, 16'd4, "lu_in_flush1");
        lu_step(1'b0, C_SQ, 16'd3, 16'd4, "lu_in_flush2");
        idle(1'b0, C_RUN, 16'd3, 16'd4, "lu_redir_done");

        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, C_SQ, 16'd3, 16'd4, "pre_rst_redir");
        idle(1'b1, C_RST, 16'd0, 16'd0, "rst_mid_flush");
        idle(1'b0, C_RST, 16'd0, 16'd0, "rst_mid_flush_hold");
        idle(1'b0, C_RUN, 16'd0, 16'd0, "no_residual_squash");

        lu_step(1'b0, C_STL, 16'd0, 16'd0, "stall_before_rst");
        idle(1'b1, C_RST, 16'd0, 16'd0, "rst_mid_stall");
        idle(1'b0, C_RST, 16'd0, 16'd0, "rst_mid_stall_hold");
        idle(1'b0, C_RUN, 16'd0, 16'd0, "after_stall_rst");

        // Continuous stalls drive stall_cnt through 16'hFFFE up to saturation.
        for (int i = 0; i <= 65537; i++) begin
            lu_step(1'b0, C_STL, (i > 65535) ? 16'hFFFF : 16'(i), 16'd0, "stall_sat");
        end
        idle(1'b0, C_RUN, 16'hFFFF, 16'd0, "stall_sat_hold");

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
